cdf_lut_builder: RTL and testbench

CDF_LUT_BUILDER -- requirements
Module: cdf_lut_builder

---
 rtl/cdf_lut_builder_pkg.sv | 24 ++
 rtl/cdf_lut_builder_seq_divider.sv | 64 ++++++
 rtl/cdf_lut_builder.sv | 183 ++++++++++++++++++
 tb/tb_cdf_lut_builder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdf_lut_builder_pkg.sv
// Shared constants, state encoding and helpers for the CDF-based equalisation LUT builder.
package cdf_lut_builder_pkg;

  localparam int NUM_BINS  = 256;
  localparam int MAX_LEVEL = 255;
  localparam int ADDR_W    = 17;
  localparam int SUM_W     = 17;
  localparam int NUM_W     = 25;

  typedef enum logic [2:0] {
    IDLE,
    PASS1,
    PASS2_RD,
    DIV,
    WRITE,
    FINISH
  } state_t;

  // Quotients above the top grey level saturate at MAX_LEVEL.
  function automatic logic [7:0] clamp_level(input logic [NUM_W-1:0] q);
    return (q > NUM_W'(MAX_LEVEL)) ? 8'(MAX_LEVEL) : q[7:0];
  endfunction

endpackage

// File: rtl/cdf_lut_builder_seq_divider.sv
// Restoring divider (25-bit dividend / 17-bit divisor) producing one quotient bit per cycle.
module seq_divider
  import cdf_lut_builder_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  logic [SUM_W-1:0] rem;
  logic [SUM_W-1:0] den;
  logic [NUM_W-1:0] quo;
  logic [4:0]       count;
  logic             active;
  logic [SUM_W:0]   shifted;
  logic [SUM_W:0]   trial;

  // A clear sign bit on the trial subtraction means the divisor fits.
  always_comb begin
    shifted = {rem, quo[NUM_W-1]};
    trial   = shifted - {1'b0, den};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem    <= '0;
      den    <= '0;
      quo    <= '0;
      count  <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem    <= '0;
        quo    <= dividend;
        den    <= divisor;
        count  <= 5'(NUM_W - 1);
        active <= 1'b1;
      end else if (active) begin
        if (!trial[SUM_W]) begin
          rem <= trial[SUM_W-1:0];
          quo <= {quo[NUM_W-2:0], 1'b1};
        end else begin
          rem <= shifted[SUM_W-1:0];
          quo <= {quo[NUM_W-2:0], 1'b0};
        end
        if (count == 5'd0) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          count <= count - 5'd1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/cdf_lut_builder.sv
// Builds a 256-entry histogram-equalisation LUT from a histogram in scratch memory.
// Define CDF_ROUND_EN to round the scaled CDF to nearest instead of truncating.
module cdf_lut_builder
  import cdf_lut_builder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HIST_BASE = 17'd0,
  parameter logic [ADDR_W-1:0] LUT_BASE  = 17'd256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] scratch_addr,
  output logic              scratch_rd_en,
  input  logic [31:0]       scratch_rdata,
  output logic              scratch_wr_en,
  output logic [31:0]       scratch_wdata,
  output logic              busy,
  output logic              done
);

  state_t           state;
  logic             rd_valid;
  logic [8:0]       issue_idx;
  logic [7:0]       recv_idx;
  logic [SUM_W-1:0] run_sum;
  logic [SUM_W-1:0] cdf;
  logic [SUM_W-1:0] cdf_min;
  logic             min_found;
  logic [SUM_W-1:0] total;
  logic [7:0]       k;

  logic [SUM_W-1:0] bin_val;
  logic [SUM_W-1:0] p1_sum;
  logic [SUM_W-1:0] p2_cdf;
  logic [SUM_W-1:0] den;
  logic [SUM_W-1:0] diff;
  logic [NUM_W-1:0] num;
  logic             div_start;
  logic             div_done;
  logic [NUM_W-1:0] div_quotient;
  logic             unused_rdata_hi;

  assign bin_val         = scratch_rdata[SUM_W-1:0];
  assign unused_rdata_hi = ^scratch_rdata[31:SUM_W];

  always_comb begin
    p1_sum = run_sum + bin_val;
    p2_cdf = cdf + bin_val;
    den    = total - cdf_min;
    diff   = (p2_cdf >= cdf_min) ? (p2_cdf - cdf_min) : '0;
`ifdef CDF_ROUND_EN
    num    = ({8'd0, diff} * NUM_W'(MAX_LEVEL)) + {9'd0, den[SUM_W-1:1]};
`else
    num    = {8'd0, diff} * NUM_W'(MAX_LEVEL);
`endif
  end

  // The divider is launched in the same cycle the re-read bin arrives.
  assign div_start = (state == PASS2_RD) && rd_valid && (den != '0);

  seq_divider u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      scratch_rd_en <= 1'b0;
      scratch_wr_en <= 1'b0;
      scratch_addr  <= '0;
      scratch_wdata <= '0;
      rd_valid      <= 1'b0;
      issue_idx     <= '0;
      recv_idx      <= '0;
      run_sum       <= '0;
      cdf           <= '0;
      cdf_min       <= '0;
      min_found     <= 1'b0;
      total         <= '0;
      k             <= '0;
    end else begin
      rd_valid <= scratch_rd_en;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= PASS1;
            busy          <= 1'b1;
            scratch_addr  <= HIST_BASE;
            scratch_rd_en <= 1'b1;
            issue_idx     <= 9'd1;
            recv_idx      <= '0;
            run_sum       <= '0;
            cdf           <= '0;
            cdf_min       <= '0;
            min_found     <= 1'b0;
            total         <= '0;
            k             <= '0;
          end
        end

        // Reads are issued every cycle; each one returns a cycle later via rd_valid.
        PASS1: begin
          if (!issue_idx[8]) begin
            scratch_addr <= HIST_BASE + {8'd0, issue_idx};
            issue_idx    <= issue_idx + 9'd1;
          end else begin
            scratch_rd_en <= 1'b0;
          end
          if (rd_valid) begin
            run_sum  <= p1_sum;
            recv_idx <= recv_idx + 8'd1;
            if (!min_found && (p1_sum != '0)) begin
              cdf_min   <= p1_sum;
              min_found <= 1'b1;
            end
            if (recv_idx == 8'd255) begin
              total         <= p1_sum;
              state         <= PASS2_RD;
              scratch_addr  <= HIST_BASE;
              scratch_rd_en <= 1'b1;
              k             <= '0;
              cdf           <= '0;
            end
          end
        end

        PASS2_RD: begin
          scratch_rd_en <= 1'b0;
          if (rd_valid) begin
            cdf <= p2_cdf;
            if (den == '0) begin
              state         <= WRITE;
              scratch_wr_en <= 1'b1;
              scratch_addr  <= LUT_BASE + {9'd0, k};
              scratch_wdata <= {24'd0, k};
            end else begin
              state <= DIV;
            end
          end
        end

        DIV: begin
          if (div_done) begin
            state         <= WRITE;
            scratch_wr_en <= 1'b1;
            scratch_addr  <= LUT_BASE + {9'd0, k};
            scratch_wdata <= {24'd0, clamp_level(div_quotient)};
          end
        end

        WRITE: begin
          scratch_wr_en <= 1'b0;
          if (k == 8'd255) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            k             <= k + 8'd1;
            scratch_addr  <= HIST_BASE + {9'd0, k} + 17'd1;
            scratch_rd_en <= 1'b1;
            state         <= PASS2_RD;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_lut_builder.sv
// Self-checking bench for cdf_lut_builder: scratch memory model plus a queue of expected LUT writes.
module tb_cdf_lut_builder;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [16:0] scratch_addr;
  logic        scratch_rd_en;
  logic [31:0] scratch_rdata;
  logic        scratch_wr_en;
  logic [31:0] scratch_wdata;
  logic        busy;
  logic        done;

  always #5 clock = ~clock;

  cdf_lut_builder dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .scratch_addr  (scratch_addr),
    .scratch_rd_en (scratch_rd_en),
    .scratch_rdata (scratch_rdata),
    .scratch_wr_en (scratch_wr_en),
    .scratch_wdata (scratch_wdata),
    .busy          (busy),
    .done          (done)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  logic [31:0] hist_mem [0:255];
  logic [7:0]  lut_mem  [0:255];
  wr_exp_t     exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          writes_seen = 0;
  int          done_count = 0;
  int          overlap_count = 0;

  // Scratch memory: one-cycle read latency; data is X whenever no read was made.
  always @(posedge clock) begin
    if (scratch_rd_en)
      scratch_rdata <= (scratch_addr < 17'd256) ? hist_mem[scratch_addr[7:0]] : 32'hDEADBEEF;
    else
      scratch_rdata <= 'x;
    if (scratch_wr_en && scratch_addr >= 17'd256 && scratch_addr < 17'd512)
      lut_mem[scratch_addr[7:0]] <= scratch_wdata[7:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  always @(negedge clock) begin
    if (scratch_rd_en && scratch_wr_en) overlap_count++;
    if (done) done_count++;
    if (scratch_wr_en) begin
      writes_seen++;
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("[TB] FAIL unexpected_write: addr %0d data %0d with empty queue", scratch_addr, scratch_wdata);
      end
      if (exp_q.size() > 0) begin
        wr_exp_t e;
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(scratch_addr), 32'(e.addr));
        checkOutput("wr_data", scratch_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadHistogram(input int kind);
    for (int i = 0; i < 256; i++) begin
      case (kind)
        0: hist_mem[i] = 32'd256;
        1: hist_mem[i] = (i == 100) ? 32'd65536 : 32'd0;
        2: hist_mem[i] = (i == 0 || i == 255) ? 32'd32768 : 32'd0;
        3: hist_mem[i] = (i == 10 || i == 20 || i == 30 || i == 40) ? 32'd16384 : 32'd0;
        4: hist_mem[i] = (i < 5) ? 32'd0 : 32'($urandom_range(0, 255));
        default: hist_mem[i] = 32'd0;
      endcase
    end
  endtask

  // Reference equalisation formula, evaluated in wide integer arithmetic.
  task automatic computeModel();
    longint s = 0;
    longint cmin = 0;
    longint tot;
    longint den;
    longint num;
    longint q;
    bit     found = 0;
    logic [7:0] e;
    for (int i = 0; i < 256; i++) begin
      s = s + longint'(hist_mem[i][16:0]);
      if (!found && s != 0) begin
        cmin = s;
        found = 1;
      end
    end
    tot = s;
    den = tot - cmin;
    s = 0;
    for (int k = 0; k < 256; k++) begin
      s = s + longint'(hist_mem[k][16:0]);
      if (den == 0) begin
        e = 8'(k);
      end else begin
        num = (s >= cmin) ? (s - cmin) * 255 : 0;
`ifdef CDF_ROUND_EN
        num = num + den / 2;
`endif
        q = num / den;
        e = (q > 255) ? 8'd255 : 8'(q);
      end
      exp_q.push_back('{addr: 17'(256 + k), data: {24'd0, e}});
    end
  endtask

  task automatic applyStimulus(input string name, input int kind, input bit second_start);
    int lat;
    loadHistogram(kind);
    computeModel();
    writes_seen = 0;
    done_count = 0;
    overlap_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({name, "_busy_after_start"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 9000) begin
      start = (second_start && (lat == 5 || lat == 300)) ? 1'b1 : 1'b0;
      tick();
      lat++;
    end
    start = 1'b0;
    checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd1);
    checkOutput({name, "_latency_ok"}, 32'(lat <= 8000), 32'd1);
    repeat (20) tick();
    checkOutput({name, "_done_count"}, 32'(done_count), 32'd1);
    checkOutput({name, "_write_count"}, 32'(writes_seen), 32'd256);
    checkOutput({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_rd_wr_overlap"}, 32'(overlap_count), 32'd0);
    checkOutput({name, "_busy_idle"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int rc;
    int guard;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rd_en", 32'(scratch_rd_en), 32'd0);
    checkOutput("reset_wr_en", 32'(scratch_wr_en), 32'd0);
    checkOutput("reset_addr", 32'(scratch_addr), 32'd0);
    checkOutput("reset_wdata", scratch_wdata, 32'd0);
    reset = 1'b0;
    tick();

    applyStimulus("uniform", 0, 1'b0);
    checkOutput("uniform_lut37", 32'(lut_mem[37]), 32'd37);
    checkOutput("uniform_lut200", 32'(lut_mem[200]), 32'd200);

    applyStimulus("single_bin", 1, 1'b0);
    checkOutput("single_lut0", 32'(lut_mem[0]), 32'd0);
    checkOutput("single_lut100", 32'(lut_mem[100]), 32'd100);
    checkOutput("single_lut255", 32'(lut_mem[255]), 32'd255);

    applyStimulus("two_ends", 2, 1'b0);
    checkOutput("ends_lut0", 32'(lut_mem[0]), 32'd0);
    checkOutput("ends_lut254", 32'(lut_mem[254]), 32'd0);
    checkOutput("ends_lut255", 32'(lut_mem[255]), 32'd255);

    applyStimulus("four_bins", 3, 1'b0);
    checkOutput("four_lut10", 32'(lut_mem[10]), 32'd0);
    checkOutput("four_lut19", 32'(lut_mem[19]), 32'd0);
    checkOutput("four_lut20", 32'(lut_mem[20]), 32'd85);
    checkOutput("four_lut30", 32'(lut_mem[30]), 32'd170);
    checkOutput("four_lut40", 32'(lut_mem[40]), 32'd255);

    applyStimulus("all_zero", 5, 1'b0);
    checkOutput("zero_lut77", 32'(lut_mem[77]), 32'd77);

    applyStimulus("restart_ignored", 3, 1'b1);

    // Abort in the second pass just as bin 50 is re-read.
    loadHistogram(4);
    computeModel();
    writes_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    rc = 0;
    guard = 0;
    while (rc < 307 && guard < 9000) begin
      if (scratch_rd_en) rc++;
      if (rc < 307) begin
        tick();
        guard++;
      end
    end
    checkOutput("abort_reached_k50", 32'(rc), 32'd307);
    checkOutput("abort_read_addr", 32'(scratch_addr), 32'd50);
    reset = 1'b1;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rd_en", 32'(scratch_rd_en), 32'd0);
    checkOutput("abort_wr_en", 32'(scratch_wr_en), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_writes_before", 32'(writes_seen), 32'd50);
    repeat (5) tick();
    checkOutput("abort_writes_after", 32'(writes_seen), 32'd50);
    reset = 1'b0;
    exp_q.delete();
    tick();

    applyStimulus("after_abort", 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
